// File: rtl/arb_pkg.sv
// arb_pkg: shared types, derived widths and the round-robin pick for rr_arbiter_fifo.
package arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int MAX_M = 8;
  function automatic int entry_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction
  function automatic int id_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction
  // Walk outward from last+1; the nearest requester is assigned last and wins.
  function automatic int rr_pick(input logic [MAX_M-1:0] req, input int last, input int n);
    int g;
    logic [2:0] idx;
    g = last;
    for (int k = MAX_M; k >= 1; k--) begin
      idx = 3'((last + k) % n);
      if (k <= n && req[idx]) g = int'(idx);
    end
    return g;
  endfunction
endpackage

// File: rtl/rr_arbiter_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count; full refuses pushes even when popped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(wr);
      rp    <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/rr_arbiter_fifo.sv
// rr_arbiter_fifo: per-master FIFOs drained round-robin onto one slave req/ack port,
// with read data routed back to the originating master.
module rr_arbiter_fifo
  import arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FIFO_AW     = 2,
  localparam int ID_W       = id_w(NUM_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  output logic [NUM_MASTERS-1:0]        m_ready,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]        fifo_empty,
  output logic                          s_req,
  output logic                          s_we,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [ID_W-1:0]               s_id,
  input  logic                          s_ack,
  input  logic [DATA_W-1:0]             s_rdata
);
  localparam int EW = entry_w(ADDR_W, DATA_W);
  state_t state, state_nxt;
  logic [ID_W-1:0] last_grant, grant;
  logic [NUM_MASTERS-1:0] full, pop, pending;
  logic [EW-1:0] head [NUM_MASTERS];
  logic [FIFO_AW:0] occ [NUM_MASTERS];
  logic take, done;
  assign m_ready = ~full;
  assign grant   = ID_W'(rr_pick(MAX_M'(pending), int'(last_grant), NUM_MASTERS));
  assign take    = state == IDLE && |pending;
  assign done    = state == BUSY && s_ack;
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_fifo
    assign pending[i] = occ[i] != '0;
    assign pop[i]     = take && grant == ID_W'(i);
    sync_fifo #(.WIDTH(EW), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (m_valid[i]),
      .pop   (pop[i]),
      .din   ({m_we[i], m_addr[i*ADDR_W +: ADDR_W], m_wdata[i*DATA_W +: DATA_W]}),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (fifo_empty[i]),
      .count (occ[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = take ? BUSY : done ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_grant <= ID_W'(NUM_MASTERS - 1);
      s_req      <= 1'b0;
      s_we       <= 1'b0;
      s_addr     <= '0;
      s_wdata    <= '0;
      s_id       <= '0;
      m_rvalid   <= '0;
      m_rdata    <= '0;
    end else begin
      m_rvalid <= (done && !s_we) ? NUM_MASTERS'(1) << s_id : '0;
      if (done && !s_we) m_rdata <= s_rdata;
      if (take) begin
        last_grant                <= grant;
        s_req                     <= 1'b1;
        {s_we, s_addr, s_wdata}   <= head[grant];
        s_id                      <= grant;
      end else if (done) s_req <= 1'b0;
    end
endmodule

// File: tb/tb_rr_arbiter_fifo.sv
// tb_rr_arbiter_fifo: directed and random scenarios checked against a transaction-level model.
module tb_rr_arbiter_fifo;
  localparam int N = 4, DW = 8, AW = 4, FAW = 2, DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] m_valid = '0, m_we = '0, m_ready, m_rvalid, fifo_empty;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata = '0;
  logic s_req, s_we, s_ack = 1'b0;
  logic [AW-1:0] s_addr;
  logic [1:0] s_id;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    id;
  } txn_t;
  txn_t pend[$];
  txn_t cur;
  bit busy;
  int last;
  logic [N-1:0] x_rvalid;
  logic [DW-1:0] x_rdata;
  int checks = 0, fails = 0;

  rr_arbiter_fifo #(.NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .FIFO_AW(FAW)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .fifo_empty(fifo_empty), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_id(s_id), .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  function automatic int cnt(input int i);
    int c = 0;
    foreach (pend[k]) if (pend[k].id == 2'(i)) c++;
    return c;
  endfunction

  function automatic int first_of(input int i);
    foreach (pend[k]) if (pend[k].id == 2'(i)) return k;
    return -1;
  endfunction

  task automatic model_reset();
    pend.delete();
    cur = '0;
    busy = 1'b0;
    last = N - 1;
    x_rvalid = '0;
    x_rdata = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] rdy;
    txn_t t;
    int h;
    for (int i = 0; i < N; i++) rdy[i] = cnt(i) < DEPTH;
    x_rvalid = '0;
    if (busy) begin
      if (s_ack) begin
        busy = 1'b0;
        if (!cur.we) begin
          x_rvalid = N'(1) << cur.id;
          x_rdata = s_rdata;
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (cnt((last + k) % N) > 0) begin
          last = (last + k) % N;
          h = first_of(last);
          cur = pend[h];
          pend.delete(h);
          busy = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (m_valid[i] && rdy[i]) begin
        t.we = m_we[i];
        t.addr = m_addr[i*AW +: AW];
        t.data = m_wdata[i*DW +: DW];
        t.id = 2'(i);
        pend.push_back(t);
      end
  endtask

  task automatic step();
    logic [N-1:0] x_ready, x_empty;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      x_ready[i] = cnt(i) < DEPTH;
      x_empty[i] = cnt(i) == 0;
    end
    checks += 5;
    if ({s_req, s_we, s_addr, s_wdata, s_id} !== {busy, cur.we, cur.addr, cur.data, cur.id}) begin
      fails++;
      $display("FAIL slave_port t=%0t got req=%b we=%b addr=%h wdata=%h id=%0d exp req=%b we=%b addr=%h wdata=%h id=%0d",
               $time, s_req, s_we, s_addr, s_wdata, s_id, busy, cur.we, cur.addr, cur.data, cur.id);
    end
    if (m_ready !== x_ready) begin
      fails++;
      $display("FAIL m_ready t=%0t got %b exp %b", $time, m_ready, x_ready);
    end
    if (fifo_empty !== x_empty) begin
      fails++;
      $display("FAIL fifo_empty t=%0t got %b exp %b", $time, fifo_empty, x_empty);
    end
    if (m_rvalid !== x_rvalid) begin
      fails++;
      $display("FAIL m_rvalid t=%0t got %b exp %b", $time, m_rvalid, x_rvalid);
    end
    if (m_rdata !== x_rdata) begin
      fails++;
      $display("FAIL m_rdata t=%0t got %h exp %h", $time, m_rdata, x_rdata);
    end
  endtask

  task automatic set_push(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_valid[i] = 1'b1;
    m_we[i] = we;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    m_valid = '0;
    s_ack = 1'b0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    checks++;
    if ({s_req, s_we, s_addr, s_wdata, s_id, m_rvalid, m_rdata} !== '0 || fifo_empty !== 4'hF || m_ready !== 4'hF) begin
      fails++;
      $display("FAIL reset_state got req=%b empty=%b ready=%b rvalid=%b rdata=%h exp req=0 empty=1111 ready=1111 rvalid=0000 rdata=00",
               s_req, fifo_empty, m_ready, m_rvalid, m_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    set_push(0, 1'b1, 4'h3, 8'hA5);
    step();
    m_valid = '0;
    step();
    checks++;
    if ({s_req, s_we, s_addr, s_wdata, s_id} !== {1'b1, 1'b1, 4'h3, 8'hA5, 2'd0}) begin
      fails++;
      $display("FAIL write_issue got req=%b we=%b addr=%h wdata=%h id=%0d exp 1 1 3 a5 0", s_req, s_we, s_addr, s_wdata, s_id);
    end
    step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    checks++;
    if (s_req !== 1'b0 || m_rvalid !== '0) begin
      fails++;
      $display("FAIL write_done got req=%b rvalid=%b exp req=0 rvalid=0000", s_req, m_rvalid);
    end
    step();
  endtask

  task automatic test_read();
    set_push(2, 1'b0, 4'h7, 8'h00);
    step();
    m_valid = '0;
    step();
    s_ack = 1'b1;
    s_rdata = 8'h5C;
    step();
    s_ack = 1'b0;
    checks++;
    if (m_rvalid !== 4'b0100 || m_rdata !== 8'h5C) begin
      fails++;
      $display("FAIL read_return got rvalid=%b rdata=%h exp 0100 5c", m_rvalid, m_rdata);
    end
    step();
    checks++;
    if (m_rvalid !== 4'b0000) begin
      fails++;
      $display("FAIL read_pulse_width got rvalid=%b exp 0000", m_rvalid);
    end
  endtask

  task automatic test_rr_order();
    int got[$];
    do_reset();
    for (int i = 0; i < N; i++) set_push(i, 1'b1, 4'(i), 8'(8'h10 + i));
    step();
    m_valid = '0;
    for (int c = 0; c < 20 && got.size() < N; c++) begin
      s_ack = s_req;
      if (s_req) got.push_back(int'(s_id));
      step();
    end
    s_ack = 1'b0;
    checks++;
    if (got.size() != N) begin
      fails++;
      $display("FAIL rr_timeout got %0d grants exp %0d", got.size(), N);
    end
    foreach (got[k]) begin
      checks++;
      if (got[k] != k) begin
        fails++;
        $display("FAIL rr_order slot %0d got id %0d exp %0d", k, got[k], k);
      end
    end
    set_push(1, 1'b1, 4'hE, 8'h77);
    step();
    m_valid = '0;
    step();
    checks++;
    if (s_req !== 1'b1 || s_id !== 2'd1) begin
      fails++;
      $display("FAIL rr_repeat got req=%b id=%0d exp req=1 id=1", s_req, s_id);
    end
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    set_push(0, 1'b1, 4'h0, 8'h11);
    step();
    m_valid = '0;
    step();
    for (int k = 0; k < DEPTH; k++) begin
      set_push(3, 1'b1, 4'(k), 8'(8'h30 + k));
      step();
    end
    checks++;
    if (m_ready[3] !== 1'b0) begin
      fails++;
      $display("FAIL full_ready got %b exp 0", m_ready[3]);
    end
    set_push(3, 1'b1, 4'h9, 8'hEE);
    step();
    m_valid = '0;
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    step();
    checks++;
    if (s_id !== 2'd3 || s_addr !== 4'h0 || m_ready[3] !== 1'b1) begin
      fails++;
      $display("FAIL full_first_pop got id=%0d addr=%h ready=%b exp id=3 addr=0 ready=1", s_id, s_addr, m_ready[3]);
    end
    for (int k = 1; k < DEPTH; k++) begin
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      step();
      checks++;
      if (s_id !== 2'd3 || s_addr !== 4'(k) || s_wdata !== 8'(8'h30 + k)) begin
        fails++;
        $display("FAIL full_drain_order got id=%0d addr=%h data=%h exp id=3 addr=%h data=%h", s_id, s_addr, s_wdata, 4'(k), 8'(8'h30 + k));
      end
    end
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    step();
    checks++;
    if (s_req !== 1'b0 || fifo_empty[3] !== 1'b1) begin
      fails++;
      $display("FAIL full_refused got req=%b empty=%b exp req=0 empty=1", s_req, fifo_empty[3]);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_push(0, 1'b1, 4'h0, 8'h01);
    step();
    m_valid = '0;
    step();
    set_push(1, 1'b1, 4'h1, 8'hB1);
    step();
    set_push(1, 1'b1, 4'h2, 8'hB2);
    step();
    m_valid = '0;
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    set_push(1, 1'b1, 4'h3, 8'hB3);
    step();
    m_valid = '0;
    checks++;
    if (s_id !== 2'd1 || s_addr !== 4'h1 || fifo_empty[1] !== 1'b0 || m_ready[1] !== 1'b1) begin
      fails++;
      $display("FAIL push_pop_same got id=%0d addr=%h empty=%b ready=%b exp id=1 addr=1 empty=0 ready=1", s_id, s_addr, fifo_empty[1], m_ready[1]);
    end
    for (int k = 2; k <= 3; k++) begin
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      step();
      checks++;
      if (s_addr !== 4'(k) || s_wdata !== 8'(8'hB0 + k)) begin
        fails++;
        $display("FAIL push_pop_order got addr=%h data=%h exp addr=%h data=%h", s_addr, s_wdata, 4'(k), 8'(8'hB0 + k));
      end
    end
    checks++;
    if (fifo_empty[1] !== 1'b1) begin
      fails++;
      $display("FAIL push_pop_empty got %b exp 1", fifo_empty[1]);
    end
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_push(0, 1'b0, 4'h5, 8'h00);
    step();
    m_valid = '0;
    step();
    for (int i = 1; i < N; i++) set_push(i, 1'b1, 4'(i), 8'(i));
    step();
    m_valid = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (s_req !== 1'b0 || fifo_empty !== 4'hF || m_ready !== 4'hF || m_rvalid !== '0) begin
      fails++;
      $display("FAIL async_reset got req=%b empty=%b ready=%b rvalid=%b exp req=0 empty=1111 ready=1111 rvalid=0000", s_req, fifo_empty, m_ready, m_rvalid);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = N - 1; i >= 0; i--) set_push(i, 1'b1, 4'(8 + i), 8'(8'h40 + i));
    step();
    m_valid = '0;
    step();
    checks++;
    if (s_req !== 1'b1 || s_id !== 2'd0) begin
      fails++;
      $display("FAIL reset_first_grant got req=%b id=%0d exp req=1 id=0", s_req, s_id);
    end
    s_ack = 1'b1;
    for (int c = 0; c < 2 * N; c++) step();
    s_ack = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i] = $urandom_range(0, 9) < 4;
        m_we[i] = $urandom_range(0, 1) == 1;
        m_addr[i*AW +: AW] = AW'($urandom);
        m_wdata[i*DW +: DW] = DW'($urandom);
      end
      s_ack = $urandom_range(0, 9) < 4;
      s_rdata = DW'($urandom);
      step();
    end
    m_valid = '0;
    for (int c = 0; c < 300 && (pend.size() != 0 || busy); c++) begin
      s_ack = $urandom_range(0, 1) == 1;
      s_rdata = DW'($urandom);
      step();
    end
    s_ack = 1'b0;
    checks++;
    if (pend.size() != 0 || busy) begin
      fails++;
      $display("FAIL random_drain_timeout got %0d pending busy=%b exp 0 pending", pend.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rr_order();
    test_full();
    test_same_cycle();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
